// File: rtl/nest_chk_pkg.sv
// Shared types and constants for the keyword nesting checker.
// Optional build macro: TAB_DELIM_EN (TAB/LF/CR count as delimiters).
package nest_chk_pkg;

    localparam logic KIND_BLOCK = 1'b0;
    localparam logic KIND_FORK  = 1'b1;

    localparam logic [2:0] LEN_BEGIN = 3'd5;
    localparam logic [2:0] LEN_END   = 3'd3;
    localparam logic [2:0] LEN_FORK  = 3'd4;
    localparam logic [2:0] LEN_JOIN  = 3'd4;
    localparam logic [2:0] POS_JUNK  = 3'd6;

    localparam logic [7:0] ASCII_SP       = 8'h20;
    localparam logic [7:0] ASCII_TAB      = 8'h09;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    typedef enum logic [2:0] {
        KW_NONE,
        KW_BEGIN,
        KW_END,
        KW_FORK,
        KW_JOIN
    } kw_t;

    function automatic logic kw_kind(input kw_t kw);
        return (kw == KW_FORK || kw == KW_JOIN) ? KIND_FORK : KIND_BLOCK;
    endfunction

    function automatic logic kw_opens(input kw_t kw);
        return (kw == KW_BEGIN || kw == KW_FORK);
    endfunction

    function automatic logic kw_closes(input kw_t kw);
        return (kw == KW_END || kw == KW_JOIN);
    endfunction

endpackage

// File: rtl/nest_kw_matcher.sv
// Case-insensitive keyword matcher: tracks position within the current
// token and one alive bit per keyword.
// Optional build macro: TAB_DELIM_EN.
//
//   state  | meaning
//   DELIM  | pos 0: between tokens, nothing pending
//   MATCH  | pos 1..5: token in progress, alive bits still narrowing
//   JUNK   | pos 6: token too long for any keyword
module nest_kw_matcher
    import nest_chk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] ch,
    output logic       is_delim,
    output kw_t        kw_pend,
    output kw_t        kw_next
);

`ifdef TAB_DELIM_EN
    localparam logic CTRL_DELIM_EN = 1'b1;
`else
    localparam logic CTRL_DELIM_EN = 1'b0;
`endif

    // alive bit order: 0 begin, 1 end, 2 fork, 3 join
    logic [2:0] pos_q, pos_d;
    logic [3:0] alive_q, alive_d;
    logic [3:0] hit;
    logic [7:0] lc;
    logic       ctrl_delim;

    function automatic logic [7:0] exp_char(input logic [1:0] k, input logic [2:0] p);
        logic [7:0] r;
        r = 8'h00;
        case (k)
            2'd0: case (p)
                3'd0: r = "b";
                3'd1: r = "e";
                3'd2: r = "g";
                3'd3: r = "i";
                3'd4: r = "n";
                default: r = 8'h00;
            endcase
            2'd1: case (p)
                3'd0: r = "e";
                3'd1: r = "n";
                3'd2: r = "d";
                default: r = 8'h00;
            endcase
            2'd2: case (p)
                3'd0: r = "f";
                3'd1: r = "o";
                3'd2: r = "r";
                3'd3: r = "k";
                default: r = 8'h00;
            endcase
            default: case (p)
                3'd0: r = "j";
                3'd1: r = "o";
                3'd2: r = "i";
                3'd3: r = "n";
                default: r = 8'h00;
            endcase
        endcase
        return r;
    endfunction

    function automatic kw_t decode(input logic [2:0] p, input logic [3:0] a);
        kw_t kw;
        kw = KW_NONE;
        if (a[0] && p == LEN_BEGIN)      kw = KW_BEGIN;
        else if (a[1] && p == LEN_END)   kw = KW_END;
        else if (a[2] && p == LEN_FORK)  kw = KW_FORK;
        else if (a[3] && p == LEN_JOIN)  kw = KW_JOIN;
        return kw;
    endfunction

    // Delimiter detection on the raw character.
    always_comb begin
        ctrl_delim = (ch == ASCII_TAB) || (ch == ASCII_LF) || (ch == ASCII_CR);
        is_delim   = (ch == ASCII_SP) || (CTRL_DELIM_EN && ctrl_delim);
    end

    // Next matcher state; a delimiter returns to DELIM, otherwise narrow alive bits.
    always_comb begin
        lc  = ch | ASCII_CASE_BIT;
        hit = '0;
        for (int k = 0; k < 4; k++) begin
            hit[k] = (lc == exp_char(2'(k), pos_q));
        end
        pos_d   = pos_q;
        alive_d = alive_q;
        if (in_valid) begin
            if (is_delim) begin
                pos_d   = 3'd0;
                alive_d = 4'h0;
            end else begin
                alive_d = ((pos_q == 3'd0) ? 4'hF : alive_q) & hit;
                pos_d   = (pos_q == POS_JUNK) ? POS_JUNK : pos_q + 3'd1;
            end
        end
        kw_pend = decode(pos_q, alive_q);
        kw_next = decode(pos_d, alive_d);
    end

    // Matcher state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q   <= 3'd0;
            alive_q <= 4'h0;
        end else begin
            pos_q   <= pos_d;
            alive_q <= alive_d;
        end
    end

endmodule

// File: rtl/nest_block_checker.sv
// Streaming begin/end + fork/join nesting checker with a kind stack.
// result looks ahead as if the token in progress were terminated now.
// Optional build macro: TAB_DELIM_EN.
module nest_block_checker
    import nest_chk_pkg::*;
#(
    parameter  int MAX_DEPTH = 8,
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               error,
    output logic               overflow
);

    logic                 is_delim;
    kw_t                  kw_pend, kw_next;
    logic [MAX_DEPTH-1:0] stack_q, stack_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d, eff_depth;
    logic                 error_q, error_d, eff_err;
    logic                 overflow_q, overflow_d;
    logic                 result_q, result_d;
    logic                 top_q, top_d;

    nest_kw_matcher u_matcher (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .ch       (in),
        .is_delim (is_delim),
        .kw_pend  (kw_pend),
        .kw_next  (kw_next)
    );

    // Commit the finished token to the stack on an accepted delimiter.
    always_comb begin
        stack_d    = stack_q;
        depth_d    = depth_q;
        error_d    = error_q;
        overflow_d = overflow_q;
        top_q      = KIND_BLOCK;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth_q) top_q = stack_q[i];
        end
        if (in_valid && is_delim) begin
            if (kw_opens(kw_pend)) begin
                if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                    overflow_d = 1'b1;
                    error_d    = 1'b1;
                end else begin
                    for (int i = 0; i < MAX_DEPTH; i++) begin
                        if (DEPTH_W'(i) == depth_q) stack_d[i] = kw_kind(kw_pend);
                    end
                    depth_d = depth_q + 1'b1;
                end
            end else if (kw_closes(kw_pend)) begin
                if (depth_q == '0) begin
                    error_d = 1'b1;
                end else begin
                    if (top_q != kw_kind(kw_pend)) error_d = 1'b1;
                    depth_d = depth_q - 1'b1;
                end
            end
        end
    end

    // Lookahead: apply the token in progress on top of the committed state.
    always_comb begin
        eff_depth = depth_d;
        eff_err   = error_d;
        top_d     = KIND_BLOCK;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth_d) top_d = stack_d[i];
        end
        if (kw_opens(kw_next)) begin
            if (depth_d == DEPTH_W'(MAX_DEPTH)) eff_err = 1'b1;
            else                                eff_depth = depth_d + 1'b1;
        end else if (kw_closes(kw_next)) begin
            if (depth_d == '0) begin
                eff_err = 1'b1;
            end else begin
                if (top_d != kw_kind(kw_next)) eff_err = 1'b1;
                eff_depth = depth_d - 1'b1;
            end
        end
        result_d = in_valid ? (!eff_err && eff_depth == '0) : result_q;
    end

    // Stack, depth, sticky flags and registered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stack_q    <= '0;
            depth_q    <= '0;
            error_q    <= 1'b0;
            overflow_q <= 1'b0;
            result_q   <= 1'b1;
        end else begin
            stack_q    <= stack_d;
            depth_q    <= depth_d;
            error_q    <= error_d;
            overflow_q <= overflow_d;
            result_q   <= result_d;
        end
    end

    assign result   = result_q;
    assign depth    = depth_q;
    assign error    = error_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_nest_block_checker.sv
// Directed bench for nest_block_checker; a MAX_DEPTH=2 copy shares the stimulus.
module tb_nest_block_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_ch = 8'h00;

    logic       result, error, overflow;
    logic [3:0] depth;
    logic       result2, error2, overflow2;
    logic [1:0] depth2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    nest_block_checker #(.MAX_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
        .result(result), .depth(depth), .error(error), .overflow(overflow)
    );

    nest_block_checker #(.MAX_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
        .result(result2), .depth(depth2), .error(error2), .overflow(overflow2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        in_ch = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input logic [7:0] c);
        in_ch = c;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        string s;
        do_reset();
        chk("rst_result", result, 1);
        chk("rst_depth", depth, 0);
        chk("rst_error", error, 0);
        chk("rst_overflow", overflow, 0);

        // nested pairs, depth steps 1,2,1,0
        send_str("begin ");  chk("nest_d1", depth, 1);
        send_str("fork ");   chk("nest_d2", depth, 2);
        send_str("join ");   chk("nest_d3", depth, 1);
        send_str("end ");    chk("nest_d4", depth, 0);
        chk("nest_result", result, 1);
        chk("nest_error", error, 0);

        // mixed case and lookahead
        do_reset();
        send_str("BeGiN");
        chk("la_begin_result", result, 0);
        chk("la_begin_depth", depth, 0);
        send_str(" EnD");
        chk("la_end_result", result, 1);
        chk("la_end_depth", depth, 1);
        send_str(" ");
        chk("la_sp_depth", depth, 0);
        chk("la_sp_result", result, 1);

        // kind mismatch, sticky error
        do_reset();
        send_str("begin join ");
        chk("mis_error", error, 1);
        chk("mis_result", result, 0);
        chk("mis_depth", depth, 0);
        send_str("end ");
        chk("mis_sticky_result", result, 0);
        chk("mis_sticky_error", error, 1);

        // overflow on the depth-2 copy, plain push on depth-8
        do_reset();
        send_str("begin begin fork");
        chk("ovf_la_result2", result2, 0);
        chk("ovf_la_error2", error2, 0);
        send_str(" ");
        chk("ovf_overflow2", overflow2, 1);
        chk("ovf_error2", error2, 1);
        chk("ovf_depth2", depth2, 2);
        chk("ovf_depth8", depth, 3);
        chk("ovf_overflow8", overflow, 0);

        // underflow, then reset mid-token
        do_reset();
        send_str("end ");
        chk("udf_error", error, 1);
        chk("udf_depth", depth, 0);
        send_str("begi");
        do_reset();
        chk("midrst_result", result, 1);
        chk("midrst_depth", depth, 0);
        chk("midrst_error", error, 0);
        send_str("begi");
        chk("begi_result", result, 1);
        do_reset();
        send_str("end ");
        chk("udf2_error", error, 1);

        // in_valid gapped; idle cycles present a space that must be ignored
        do_reset();
        s = "fork join ";
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            idle(8'h20);
            if (i == 3) chk("gap_no_commit", depth, 0);
            if (i == 4) chk("gap_d1", depth, 1);
        end
        chk("gap_depth", depth, 0);
        chk("gap_result", result, 1);
        chk("gap_error", error, 0);

        // junk tokens
        do_reset();
        send_str("forkx join ");
        chk("junk_error", error, 1);
        chk("junk_depth", depth, 0);
        do_reset();
        send_str("begin ends ");
        chk("ends_depth", depth, 1);
        chk("ends_error", error, 0);
        do_reset();
        send_str("beginx");
        chk("beginx_result", result, 1);

        // control-character delimiters
        do_reset();
        send_str("begin\t");
`ifdef TAB_DELIM_EN
        chk("tab_d1", depth, 1);
        chk("tab_r1", result, 0);
`else
        chk("tab_d1", depth, 0);
        chk("tab_r1", result, 1);
`endif
        send_str("end\t");
        chk("tab_depth", depth, 0);
        chk("tab_result", result, 1);
        chk("tab_error", error, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
